// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle ARM-subset control unit (main FSM, ALU decode, NZCV flags, condition gating)
//
// Sequences the shared datapath (one memory, one ALU) through fetch/decode/execute steps
// for DP reg/imm, LDR/STR and B instructions.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low (0 = in reset)
//   Cond/Op/Funct/Rd   instruction fields Instr[31:28]/[27:26]/[25:20]/[15:12]
//   ALUFlags    live ALU result flags {N,Z,C,V}
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
//   ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite   datapath controls
//   Flags       current flag register {N,Z,C,V}
module multicycle_controller #(
   parameter logic [3:0] FLAGS_RST = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] ALUFlags,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUControl,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic       RegWrite,
   output logic [3:0] Flags
);

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BRANCH
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] flags_q, flags_d;
   logic       cond_q, cond_d;

   // Raw (ungated) per-state controls
   logic       next_pc;
   logic       branch;
   logic       reg_w;
   logic       mem_w;
   logic       alu_op;
   logic       ir_write;
   logic       adr_src;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;

   logic [1:0] alu_control;
   logic [1:0] flag_w;
   logic       cond_ex;
   logic       pcs;

   // Next-state logic
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (Op)
               2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
               2'b01:   state_d = S_MEMADR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = S_MEMWB;
         S_EXECR:  state_d = S_ALUWB;
         S_EXECI:  state_d = S_ALUWB;
         default:  state_d = S_FETCH;
      endcase
   end

   // Per-state raw controls, decoded from the state register
   always_comb begin
      next_pc    = 1'b0;
      branch     = 1'b0;
      reg_w      = 1'b0;
      mem_w      = 1'b0;
      alu_op     = 1'b0;
      ir_write   = 1'b0;
      adr_src    = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      case (state_q)
         S_FETCH: begin
            ir_write   = 1'b1;
            next_pc    = 1'b1;
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
         end
         S_DECODE: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
         end
         S_MEMADR: alu_src_b = 2'b01;
         S_MEMRD:  adr_src = 1'b1;
         S_MEMWB: begin
            result_src = 2'b01;
            reg_w      = 1'b1;
         end
         S_MEMWR: begin
            adr_src = 1'b1;
            mem_w   = 1'b1;
         end
         S_EXECR: alu_op = 1'b1;
         S_EXECI: begin
            alu_src_b = 2'b01;
            alu_op    = 1'b1;
         end
         S_ALUWB: reg_w = 1'b1;
         S_BRANCH: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            branch     = 1'b1;
         end
         default: ;
      endcase
   end

   // ALU decode; unsupported DP opcodes fall back to ADD and never touch the flags
   always_comb begin
      alu_control = 2'b00;
      flag_w      = 2'b00;
      if (alu_op) begin
         case (Funct[4:1])
            4'b0100: begin alu_control = 2'b00; flag_w = {Funct[0], Funct[0]}; end
            4'b0010: begin alu_control = 2'b01; flag_w = {Funct[0], Funct[0]}; end
            4'b0000: begin alu_control = 2'b10; flag_w = {Funct[0], 1'b0};     end
            4'b1100: begin alu_control = 2'b11; flag_w = {Funct[0], 1'b0};     end
            default: begin alu_control = 2'b00; flag_w = 2'b00;                end
         endcase
      end
   end

   // Condition check against the committed flag register
   always_comb begin
      logic n, z, c, v;
      {n, z, c, v} = flags_q;
      cond_ex = 1'b0;
      case (Cond)
         4'b0000: cond_ex = z;
         4'b0001: cond_ex = ~z;
         4'b0010: cond_ex = c;
         4'b0011: cond_ex = ~c;
         4'b0100: cond_ex = n;
         4'b0101: cond_ex = ~n;
         4'b0110: cond_ex = v;
         4'b0111: cond_ex = ~v;
         4'b1000: cond_ex = c & ~z;
         4'b1001: cond_ex = ~c | z;
         4'b1010: cond_ex = (n == v);
         4'b1011: cond_ex = (n != v);
         4'b1100: cond_ex = ~z & (n == v);
         4'b1101: cond_ex = z | (n != v);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // cond_q is captured once per instruction in DECODE, so a flag update in EXEC
   // can never change the verdict for the instruction that produced it.
   always_comb begin
      cond_d  = (state_q == S_DECODE) ? cond_ex : cond_q;
      flags_d = flags_q;
      if (cond_q && flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
      if (cond_q && flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         flags_q <= FLAGS_RST;
         cond_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
         cond_q  <= cond_d;
      end
   end

   // Write enables are masked by reset so nothing commits while it is held low
   always_comb begin
      pcs        = ((Rd == 4'hF) & reg_w) | branch;
      PCWrite    = reset & (next_pc | (pcs & cond_q));
      IRWrite    = reset & ir_write;
      RegWrite   = reset & reg_w & cond_q;
      MemWrite   = reset & mem_w & cond_q;
      AdrSrc     = adr_src;
      ResultSrc  = result_src;
      ALUControl = alu_control;
      ALUSrcA    = alu_src_a;
      ALUSrcB    = alu_src_b;
      ImmSrc     = Op;
      RegSrc     = {Op == 2'b01, Op == 2'b10};
      Flags      = flags_q;
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

   localparam logic [3:0] FR = 4'b0000;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUControl, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
   logic [3:0] Flags;

   multicycle_controller #(.FLAGS_RST(FR)) dut (
      .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
      .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
      .RegWrite(RegWrite), .Flags(Flags)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference state: committed flags and the instruction currently presented
   logic [3:0] mflags;
   logic [3:0] cur_cond;
   logic [1:0] cur_op;
   logic [5:0] cur_funct;
   logic [3:0] cur_rd;
   logic       fix_alu = 1'b0;
   logic [3:0] fix_val = 4'b0000;

   logic [20:0] obs_vec;
   assign obs_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
                     ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite, Flags};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cy;
         4'h3: return !cy;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cy && !z;
         4'h9: return !cy || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [20:0] pack(input logic pcw, input logic adr, input logic mw,
                                        input logic irw, input logic [1:0] rs, input logic [1:0] alu,
                                        input logic [1:0] sa, input logic [1:0] sb, input logic rw);
      logic [1:0] regsrc;
      regsrc = {cur_op == 2'b01, cur_op == 2'b10};
      return {pcw, adr, mw, irw, rs, alu, sa, sb, cur_op, regsrc, rw, mflags};
   endfunction

   // One clock cycle: present inputs, compare all outputs, then apply any flag update
   task automatic step(input string tag, input logic [20:0] exp, input logic is_exec,
                       input logic fw1, input logic fw0, input logic ok);
      @(negedge clk);
      Cond     = cur_cond;
      Op       = cur_op;
      Funct    = cur_funct;
      Rd       = cur_rd;
      ALUFlags = fix_alu ? fix_val : 4'($urandom);
      #1;
      check(tag, {11'b0, obs_vec}, {11'b0, exp});
      @(posedge clk);
      if (is_exec && ok) begin
         if (fw1) mflags[3:2] = ALUFlags[3:2];
         if (fw0) mflags[1:0] = ALUFlags[1:0];
      end
   endtask

   task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                            input logic [3:0] r);
      logic       ok, known, fw1, fw0, pc_rd;
      logic [1:0] ctl;
      cur_cond  = c;
      cur_op    = o;
      cur_funct = f;
      cur_rd    = r;
      ok        = cond_holds(c, mflags);
      known     = 1'b1;
      case (f[4:1])
         4'b0100: ctl = 2'd0;
         4'b0010: ctl = 2'd1;
         4'b0000: ctl = 2'd2;
         4'b1100: ctl = 2'd3;
         default: begin ctl = 2'd0; known = 1'b0; end
      endcase
      fw1   = f[0] && known;
      fw0   = f[0] && known && (f[4:1] == 4'b0100 || f[4:1] == 4'b0010);
      pc_rd = (r == 4'hF) && ok;
      step("fetch",  pack(1, 0, 0, 1, 2'b10, 2'b00, 2'b01, 2'b10, 0), 0, 0, 0, ok);
      step("decode", pack(0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b10, 0), 0, 0, 0, ok);
      case (o)
         2'b00: begin
            step("exec",  pack(0, 0, 0, 0, 2'b00, ctl, 2'b00, f[5] ? 2'b01 : 2'b00, 0), 1, fw1, fw0, ok);
            step("aluwb", pack(pc_rd, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, ok), 0, 0, 0, ok);
         end
         2'b01: begin
            step("memadr", pack(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0), 0, 0, 0, ok);
            if (f[0]) begin
               step("memrd", pack(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 0, 0, 0, ok);
               step("memwb", pack(pc_rd, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, ok), 0, 0, 0, ok);
            end else begin
               step("memwr", pack(0, 1, ok, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 0, 0, 0, ok);
            end
         end
         2'b10: step("branch", pack(ok, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b01, 0), 0, 0, 0, ok);
         default: ;
      endcase
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      Cond = 4'hE; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
      cur_cond = 4'hE; cur_op = 2'b00; cur_funct = 6'd0; cur_rd = 4'd0;
      mflags = FR;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check("reset_outputs", {11'b0, obs_vec},
            {11'b0, pack(0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b10, 0)});
      @(posedge clk); #2;
      reset = 1'b1;

      run_instr(4'hE, 2'b00, 6'b001000, 4'd1);            // ADD R1,R2,R3
      run_instr(4'hE, 2'b01, 6'b011001, 4'd2);            // LDR
      fix_alu = 1'b1; fix_val = 4'b0100;
      run_instr(4'hE, 2'b00, 6'b000101, 4'd3);            // SUBS -> Z
      check("subs_flags", {28'b0, Flags}, 32'h4);
      run_instr(4'h0, 2'b10, 6'b000000, 4'd0);            // BEQ taken
      run_instr(4'h1, 2'b01, 6'b011000, 4'd4);            // STRNE, Z=1
      fix_val = 4'b1011;
      run_instr(4'h1, 2'b00, 6'b000001, 4'd5);            // ANDSNE fails
      check("ands_fail_flags", {28'b0, Flags}, 32'h4);
      fix_val = 4'b0000;
      run_instr(4'hE, 2'b00, 6'b000101, 4'd3);            // SUBS -> Z=0
      run_instr(4'h0, 2'b10, 6'b000000, 4'd0);            // BEQ not taken
      run_instr(4'hE, 2'b00, 6'b001000, 4'hF);            // ADD PC
      run_instr(4'hE, 2'b11, 6'b000000, 4'd0);            // Op=11
      fix_val = 4'b1011;
      run_instr(4'hE, 2'b00, 6'b001001, 4'd6);            // ADDS -> 1011
      fix_alu = 1'b0;

      // Reset during MEMRD of an LDR
      cur_cond = 4'hE; cur_op = 2'b01; cur_funct = 6'b011001; cur_rd = 4'hF;
      step("rst_fetch",  pack(1, 0, 0, 1, 2'b10, 2'b00, 2'b01, 2'b10, 0), 0, 0, 0, 1);
      step("rst_decode", pack(0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b10, 0), 0, 0, 0, 1);
      step("rst_memadr", pack(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0), 0, 0, 0, 1);
      @(negedge clk); #1;
      check("rst_memrd", {11'b0, obs_vec}, {11'b0, pack(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0)});
      #1 reset = 1'b0;
      #1;
      mflags = FR;
      check("rst_async", {11'b0, obs_vec}, {11'b0, pack(0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b10, 0)});
      @(posedge clk); @(negedge clk); #1;
      check("rst_held", {11'b0, obs_vec}, {11'b0, pack(0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b10, 0)});
      @(posedge clk); #2;
      reset = 1'b1;
      run_instr(4'hE, 2'b00, 6'b101000, 4'd7);            // ADD imm after reset

      for (int i = 0; i < 300; i++) begin
         logic [5:0] f;
         f = 6'($urandom);
         if (($urandom & 3) == 0) f[4:1] = 4'b0010;
         run_instr(4'($urandom), 2'($urandom), f, 4'($urandom_range(0, 15)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
